// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory for the load/store path: byte/half/word
// access, sign/zero extension, error reporting and a post-reset clear sweep.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      zero-extend sub-word loads
//   req_addr          byte address
//   req_wdata         store data (low bits for byte/half)
//   rsp_valid         response, one cycle after acceptance
//   rsp_rdata         extended load data, 0 for stores/errors
//   rsp_err           misaligned, out of range or illegal size
//   busy              clear sweep in progress
module data_memory_ctrl #(
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] clear_ptr_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic [31:0]      rsp_rdata_q;
    logic [31:0]      mem_q [DEPTH];

    logic [IDX_W-1:0] idx;
    logic             oor;
    logic             misalign;
    logic             size_bad;
    logic             err;
    logic             accept;
    logic             wr_en;
    logic [3:0]       be;
    logic [31:0]      wlanes;
    logic [31:0]      rd_word;
    logic [31:0]      shifted;
    logic [31:0]      rdata_d;

    assign idx      = req_addr[IDX_W+1:2];
    assign oor      = |req_addr[ADDR_W-1:IDX_W+2];
    assign size_bad = (req_size == 2'b11);
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign err      = oor | misalign | size_bad;

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_CLEAR);
    assign accept    = req_valid && req_ready;
    // A store in the reset cycle must not land in the array.
    assign wr_en     = accept && req_we && !err && !reset;

    assign rd_word = mem_q[idx];
    // Move the addressed byte/half down to bit 0.
    assign shifted = rd_word >> {req_addr[1:0], 3'b000};

    always_comb begin
        be      = 4'b0000;
        wlanes  = req_wdata;
        rdata_d = '0;
        case (req_size)
            2'b00: begin
                be      = 4'b0001 << req_addr[1:0];
                wlanes  = {4{req_wdata[7:0]}};
                rdata_d = req_unsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                be      = req_addr[1] ? 4'b1100 : 4'b0011;
                wlanes  = {2{req_wdata[15:0]}};
                rdata_d = req_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            end
            2'b10: begin
                be      = 4'b1111;
                wlanes  = req_wdata;
                rdata_d = rd_word;
            end
            default: begin
                be      = 4'b0000;
                wlanes  = req_wdata;
                rdata_d = '0;
            end
        endcase
    end

    // Array: sweep writes zeros, otherwise byte-lane stores.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == S_CLEAR) begin
                mem_q[clear_ptr_q] <= '0;
            end else if (wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[idx][8*b +: 8] <= wlanes[8*b +: 8];
                    end
                end
            end
        end
    end

    // Control FSM with registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            clear_ptr_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && err;
            rsp_rdata_q <= (accept && !err && !req_we) ? rdata_d : '0;
            case (state_q)
                S_CLEAR: begin
                    if (clear_ptr_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= S_IDLE;
                    end
                    clear_ptr_q <= clear_ptr_q + IDX_W'(1);
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: directed load/store cases, error cases,
// clear sweep timing and randomized traffic against a byte-array model.
module tb_data_memory_ctrl;

    localparam int DEPTH = 256;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    data_memory_ctrl #(
        .DEPTH(DEPTH),
        .ADDR_W(32),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mbytes [NBYTES];

    bit          exp_v;
    bit          exp_e;
    logic [31:0] exp_rd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'h00;
    endtask

    // Reference: little-endian byte array with plain arithmetic extension.
    task automatic model_req(input bit we, input bit [1:0] sz,
                             input bit uns, input logic [31:0] a,
                             input logic [31:0] wd,
                             output bit e, output logic [31:0] rd);
        int nb;
        longint val;
        e = (a >= NBYTES) || (sz == 2'd3) ||
            (sz == 2'd1 && (a % 2) != 0) ||
            (sz == 2'd2 && (a % 4) != 0);
        rd = '0;
        if (e) return;
        nb = 1 << sz;
        if (we) begin
            for (int i = 0; i < nb; i++) mbytes[a + i] = wd[8*i +: 8];
        end else begin
            val = 0;
            for (int i = 0; i < nb; i++)
                val = val + (longint'(mbytes[a + i]) << (8 * i));
            if (!uns && nb < 4 && val >= (longint'(1) << (8 * nb - 1)))
                val = val - (longint'(1) << (8 * nb));
            rd = val[31:0];
        end
    endtask

    task automatic check_rsp();
        chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_v});
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_e});
        chk("rsp_rdata", rsp_rdata, exp_rd);
    endtask

    // One request slot: check previous response, then drive the new one.
    task automatic cycle(input bit v, input bit we, input bit [1:0] sz,
                         input bit uns, input logic [31:0] a,
                         input logic [31:0] wd);
        bit e;
        logic [31:0] rd;
        @(negedge clk);
        check_rsp();
        req_valid    = v;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        exp_v  = 1'b0;
        exp_e  = 1'b0;
        exp_rd = '0;
        if (v) begin
            chk("req_ready", {31'h0, req_ready}, 32'h1);
            model_req(we, sz, uns, a, wd, e, rd);
            exp_v  = 1'b1;
            exp_e  = e;
            exp_rd = rd;
        end
    endtask

    // Called at the negedge right after the reset edge.
    task automatic count_sweep(input string tag);
        int cnt = 0;
        while (busy && cnt < 1000) begin
            if (req_ready !== 1'b0) chk("ready_in_clear", {31'h0, req_ready}, 32'h0);
            cnt++;
            @(negedge clk);
        end
        chk(tag, cnt, DEPTH);
        chk("ready_after_clear", {31'h0, req_ready}, 32'h1);
        model_clear();
        exp_v  = 1'b0;
        exp_e  = 1'b0;
        exp_rd = '0;
    endtask

    task automatic idle_inputs();
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
    endtask

    localparam bit LD = 1'b0;
    localparam bit ST = 1'b1;

    initial begin
        logic [31:0] a;
        bit [1:0] sz;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {31'h0, busy}, 32'h1);
        chk("reset_ready", {31'h0, req_ready}, 32'h0);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        count_sweep("sweep_len");

        // Cleared array reads zero.
        cycle(1, LD, 2, 0, 32'h000, 0);
        cycle(1, LD, 2, 0, 32'h3FC, 0);
        cycle(1, LD, 2, 0, 32'h1A0, 0);

        // Extension cases.
        cycle(1, ST, 2, 0, 32'h10, 32'h80FF7F01);
        cycle(1, LD, 0, 0, 32'h10, 0);
        cycle(1, LD, 0, 0, 32'h13, 0);
        cycle(1, LD, 0, 1, 32'h13, 0);
        cycle(1, LD, 1, 0, 32'h12, 0);
        cycle(1, LD, 1, 1, 32'h12, 0);

        // Lane merging.
        cycle(1, ST, 2, 0, 32'h20, 32'h11223344);
        cycle(1, ST, 0, 0, 32'h21, 32'hFFFFFFAA);
        cycle(1, ST, 1, 0, 32'h22, 32'h1234BEEF);
        cycle(1, LD, 2, 0, 32'h20, 0);

        // Errors, then no corruption.
        cycle(1, LD, 1, 0, 32'h21, 0);
        cycle(1, LD, 2, 0, 32'h22, 0);
        cycle(1, LD, 3, 0, 32'h20, 0);
        cycle(1, LD, 2, 0, 32'h400, 0);
        cycle(1, ST, 2, 0, 32'h21, 32'hDEADDEAD);
        cycle(1, ST, 3, 0, 32'h20, 32'hDEADDEAD);
        cycle(1, ST, 2, 0, 32'h80000020, 32'hDEADDEAD);
        cycle(1, LD, 2, 0, 32'h20, 0);

        // Store then load on consecutive cycles.
        cycle(1, ST, 2, 0, 32'h30, 32'hCAFEBABE);
        cycle(1, LD, 2, 0, 32'h30, 0);
        cycle(0, LD, 2, 0, 0, 0);
        cycle(0, LD, 2, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) a = $urandom;
            else a = $urandom_range(0, NBYTES - 1);
            if ($urandom_range(0, 9) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            if (sz == 2'd3 && $urandom_range(0, 3) != 0) sz = 2'd2;
            cycle($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                  sz, $urandom_range(0, 1) == 1, a, $urandom);
        end
        cycle(0, LD, 2, 0, 0, 0);

        // Reset 100 cycles into a sweep with a store presented.
        @(negedge clk);
        check_rsp();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_sweep_busy", {31'h0, busy}, 32'h1);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h30;
        req_wdata = 32'h5A5A5A5A;
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        chk("restart_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        count_sweep("restart_sweep_len");
        cycle(1, LD, 2, 0, 32'h30, 0);
        cycle(1, LD, 2, 0, 32'h10, 0);

        // Reset while a store is accepted in IDLE.
        cycle(1, ST, 2, 0, 32'h40, 32'h01020304);
        @(negedge clk);
        check_rsp();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h44;
        req_wdata = 32'h77777777;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        chk("idle_reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        count_sweep("idle_reset_sweep_len");
        cycle(1, LD, 2, 0, 32'h44, 0);
        cycle(1, LD, 2, 0, 32'h40, 0);
        cycle(0, LD, 2, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised data memory for the RISC-V core's load/store path, replacing the fixed 64-word, word-only memory. Adds byte and halfword access with sign/zero extension, byte-lane write enables, and a valid/ready request port with a registered response. Also adds misalignment and out-of-range error reporting, plus a post-reset clear sequencer. Sits between the core's memory stage and the writeback mux.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, 4..4096.
ADDR_W, 32, byte-address width of req_addr.
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset via the sweep FSM; 0 = contents undefined and the block is ready immediately.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
req_unsigned  in  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data; the low bits supply the byte or half.
rsp_valid  out  1  response for the request accepted in the previous cycle.
rsp_rdata  out  32  extended load data; 0 for stores and errors.
rsp_err  out  1  request rejected (misaligned, out of range, or illegal size).
busy  out  1  clear sweep in progress.

Behaviour:
- Handshake: a request is accepted when req_valid && req_ready. req_ready = 1 in IDLE and 0 in CLEAR. Throughput is one request per cycle with no back-pressure on the response.
- Latency: rsp_valid pulses exactly 1 cycle after each accepted request, loads and stores alike. rsp_rdata and rsp_err are valid only while rsp_valid = 1 and are 0 otherwise.
- Word index = req_addr[log2(DEPTH)+1:2].
- Out of range: any of req_addr[ADDR_W-1:log2(DEPTH)+2] nonzero sets rsp_err = 1.
- Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0, sets rsp_err = 1.
- req_size = 11 sets rsp_err = 1.
- Any error: no array write and rsp_rdata = 0.
- Store lanes:
  - byte: lane addr[1:0] gets req_wdata[7:0].
  - half: lanes {addr[1],1} and {addr[1],0} get req_wdata[15:0].
  - word: all 4 lanes.
  - Unselected lanes are unchanged. The write commits on the accepting edge.
- Load: the selected byte or half is shifted to bit 0, then sign- or zero-extended per req_unsigned. A word load ignores req_unsigned. Data is sampled from the array at the accepting edge.
- Back-to-back store then load to the same word (consecutive cycles): the load returns the newly stored data.
- FSM states:
  - RESET_ENTRY: reset = 1. Forces state to CLEAR if CLEAR_ON_RESET = 1, else IDLE. Sets clear_ptr = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - CLEAR: writes 0 to word clear_ptr each cycle and increments clear_ptr. At clear_ptr = DEPTH-1, writes it and goes to IDLE. busy = 1, req_ready = 0. The sweep takes exactly DEPTH cycles after reset deasserts.
  - IDLE: busy = 0, req_ready = 1, serves requests.
- Reset asserted mid-sweep or mid-request: the sweep restarts from 0, the pending response is dropped (rsp_valid = 0 next cycle), and any store accepted in the same cycle as reset is not committed.
- Reset values: req_ready = 0 if CLEAR_ON_RESET, else 1. busy = CLEAR_ON_RESET. rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.

Test Plan:
- Reset 1 cycle, CLEAR_ON_RESET = 1, DEPTH = 256 -> busy = 1 and req_ready = 0 for exactly 256 cycles, then a load of any word returns 0x00000000.
- SW 0x80FF7F01 @0x10; LB @0x10; LB @0x13; LBU @0x13; LH @0x12; LHU @0x12 -> rsp_rdata = 0x00000001, 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF, each 1 cycle after acceptance.
- SW 0x11223344 @0x20; SB 0xAA @0x21; SH 0xBEEF @0x22; LW @0x20 -> 0xBEEFAA44.
- LH @0x21, LW @0x22, req_size = 11, LW @0x400 (DEPTH = 256) -> rsp_err = 1 and rsp_rdata = 0 for each. A following LW @0x20 shows no corruption.
- Back-to-back: SW 0xCAFEBABE @0x30 in cycle N, LW @0x30 in cycle N+1 -> rsp_rdata = 0xCAFEBABE in cycle N+2.
- Assert reset 100 cycles into the sweep, with a store pending in the same cycle -> clear restarts (256 more busy cycles), no response is emitted, and the stored address reads 0 afterwards.
